lsu_bus_master: RTL and testbench

Load/store initiator that drives the single-cycle memory-mapped peripheral bus (addr/wdata/wstrb/read_en in, rdata/addr_valid out) used by the CLINT and sibling peripherals. It accepts byte/half/word load and store requests from the CPU pipeline, places write data on byte lanes with matching strobes, and issues a registered bus beat. It then aligns and sign- or zero-extends read data and reports unmapped-address and misalignment faults. It sits between the execute stage and the peripheral address decoder.

---
 rtl/lsu_bus_master.sv | 217 +++++++++++++++++++++
 tb/tb_lsu_bus_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_master.sv
// rtl/lsu_bus_master.sv - load/store initiator issuing registered beats on the single-cycle peripheral bus
// Optional feature macro LSU_MISALIGN_SPLIT_EN: perform misaligned half/word accesses (two beats when crossing a word).
module lsu_bus_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_misalign,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  output logic        bus_read_en,
  input  logic [31:0] bus_rdata,
  input  logic        bus_addr_valid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
  localparam logic [1:0] ACC1 = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic        split_q, split_d;
  logic [31:0] hi_wdata_q, hi_wdata_d;
  logic [3:0]  hi_wstrb_q, hi_wstrb_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic        bus_read_en_q, bus_read_en_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_misalign_q, rsp_misalign_d;

  logic [3:0]  size_mask;
  logic [63:0] lane_wdata;
  logic [7:0]  lane_strb;
  logic        misalign_fault;
  logic        crosses_word;

  // Lane placement spans two words; the upper half feeds the second beat of a split access.
  always_comb begin
    case (req_size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_wdata = {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
    lane_strb  = {4'd0, size_mask} << req_addr[1:0];
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  assign misalign_fault = 1'b0;
  assign crosses_word   = ((req_size == 2'b01) && (req_addr[1:0] == 2'b11)) ||
                          ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_fault = ((req_size == 2'b01) && req_addr[0]) ||
                          ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign crosses_word   = 1'b0;
`endif

  function automatic logic [31:0] extend_load(input logic [63:0] pair, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = 32'(pair >> {off, 3'b000});
    case (size)
      2'b00:   return {{24{~uns & sh[7]}}, sh[7:0]};
      2'b01:   return {{16{~uns & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    size_d         = size_q;
    uns_d          = uns_q;
    off_d          = off_q;
    split_d        = split_q;
    hi_wdata_d     = hi_wdata_q;
    hi_wstrb_d     = hi_wstrb_q;
    rdata0_d       = rdata0_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    bus_wstrb_d    = 4'b0000;
    bus_read_en_d  = 1'b0;
    rsp_valid_d    = 1'b0;
    rsp_rdata_d    = 32'd0;
    rsp_err_d      = 1'b0;
    rsp_misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          size_d     = req_size;
          uns_d      = req_unsigned;
          off_d      = req_addr[1:0];
          split_d    = crosses_word;
          hi_wdata_d = lane_wdata[63:32];
          hi_wstrb_d = lane_strb[7:4];
          if (req_size == 2'b11) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (misalign_fault) begin
            state_d        = RESP;
            rsp_valid_d    = 1'b1;
            rsp_misalign_d = 1'b1;
          end else begin
            state_d    = ACC0;
            bus_addr_d = {req_addr[31:2], 2'b00};
            if (req_we) begin
              bus_wdata_d = lane_wdata[31:0];
              bus_wstrb_d = lane_strb[3:0];
            end else begin
              bus_wdata_d   = 32'd0;
              bus_read_en_d = 1'b1;
            end
          end
        end
      end
      ACC0: begin
        rdata0_d = bus_rdata;
        if (!bus_addr_valid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (split_q) begin
          state_d    = ACC1;
          bus_addr_d = bus_addr_q + 32'd4;
          if (we_q) begin
            bus_wdata_d = hi_wdata_q;
            bus_wstrb_d = hi_wstrb_q;
          end else begin
            bus_read_en_d = 1'b1;
          end
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          if (!we_q) rsp_rdata_d = extend_load({32'd0, bus_rdata}, off_q, size_q, uns_q);
        end
      end
      ACC1: begin
        // A store beat already committed in ACC0 is not rolled back on a second-beat fault.
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        if (!bus_addr_valid) rsp_err_d = 1'b1;
        else if (!we_q) rsp_rdata_d = extend_load({bus_rdata, rdata0_q}, off_q, size_q, uns_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      we_q           <= 1'b0;
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      off_q          <= 2'b00;
      split_q        <= 1'b0;
      hi_wdata_q     <= 32'd0;
      hi_wstrb_q     <= 4'b0000;
      rdata0_q       <= 32'd0;
      bus_addr_q     <= 32'd0;
      bus_wdata_q    <= 32'd0;
      bus_wstrb_q    <= 4'b0000;
      bus_read_en_q  <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= 32'd0;
      rsp_err_q      <= 1'b0;
      rsp_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      we_q           <= we_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      off_q          <= off_d;
      split_q        <= split_d;
      hi_wdata_q     <= hi_wdata_d;
      hi_wstrb_q     <= hi_wstrb_d;
      rdata0_q       <= rdata0_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      bus_wstrb_q    <= bus_wstrb_d;
      bus_read_en_q  <= bus_read_en_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      rsp_misalign_q <= rsp_misalign_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_misalign = rsp_misalign_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_wstrb    = bus_wstrb_q;
  assign bus_read_en  = bus_read_en_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb/tb_lsu_bus_master.sv - table-driven bench for lsu_bus_master, expectations follow LSU_MISALIGN_SPLIT_EN
module tb_lsu_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_misalign;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_read_en;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_addr_valid = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_bus_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_misalign(rsp_misalign),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_read_en(bus_read_en),
    .bus_rdata(bus_rdata), .bus_addr_valid(bus_addr_valid)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        av0;
    logic        av1;
    int          beats;
    int          lat;
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [3:0]  s1;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (case %0d): got %h expected %h", name, id, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rd0, input logic [31:0] rd1,
                     input logic av0, input logic av1, input int beats, input int lat,
                     input logic [31:0] a0, input logic [3:0] s0, input logic [3:0] s1,
                     input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] rdata,
                     input logic err, input logic mis);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rd0 = rd0; v.rd1 = rd1; v.av0 = av0; v.av1 = av1; v.beats = beats; v.lat = lat;
    v.a0 = a0; v.s0 = s0; v.s1 = s1; v.w0 = w0; v.w1 = w1; v.rdata = rdata; v.err = err; v.mis = mis;
    vecs.push_back(v);
  endtask

  // Entered and left at a negedge; cycle k after the accept edge is sampled at its negedge.
  task automatic run_vec(input int id);
    vec_t v;
    int beats;
    int nrsp;
    int lat;
    v = vecs[id];
    beats = 0;
    nrsp = 0;
    lat = -1;
    chk("req_ready_idle", id, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (bus_wstrb != 4'b0000 || bus_read_en) begin
        if (beats == 0) begin
          chk("beat0_addr", id, bus_addr, v.a0);
          chk("beat0_wstrb", id, {28'd0, bus_wstrb}, {28'd0, v.s0});
          chk("beat0_read_en", id, {31'd0, bus_read_en}, {31'd0, ~v.we});
          if (v.we) chk("beat0_wdata", id, bus_wdata, v.w0);
          bus_rdata = v.rd0;
          bus_addr_valid = v.av0;
        end else begin
          chk("beat1_addr", id, bus_addr, v.a0 + 32'd4);
          chk("beat1_wstrb", id, {28'd0, bus_wstrb}, {28'd0, v.s1});
          chk("beat1_read_en", id, {31'd0, bus_read_en}, {31'd0, ~v.we});
          if (v.we) chk("beat1_wdata", id, bus_wdata, v.w1);
          bus_rdata = v.rd1;
          bus_addr_valid = v.av1;
        end
        beats++;
      end else begin
        bus_rdata = 32'hDEADBEEF;
        bus_addr_valid = 1'b0;
      end
      if (rsp_valid) begin
        nrsp++;
        if (lat < 0) lat = k;
        chk("rsp_rdata", id, rsp_rdata, v.rdata);
        chk("rsp_err", id, {31'd0, rsp_err}, {31'd0, v.err});
        chk("rsp_misalign", id, {31'd0, rsp_misalign}, {31'd0, v.mis});
      end
    end
    chk("beat_count", id, beats, v.beats);
    chk("rsp_pulses", id, nrsp, 1);
    chk("rsp_latency", id, lat, v.lat);
  endtask

  initial begin
    add(1, 2'b10, 0, 32'h02004000, 32'h00000040, 0, 0, 1, 1, 1, 2, 32'h02004000, 4'hF, 4'h0, 32'h00000040, 0, 0, 0, 0);
    add(1, 2'b00, 0, 32'h0200BFFA, 32'h000000AB, 0, 0, 1, 1, 1, 2, 32'h0200BFF8, 4'h4, 4'h0, 32'h00AB0000, 0, 0, 0, 0);
    add(0, 2'b00, 0, 32'h02004000, 0, 32'h00000080, 0, 1, 1, 1, 2, 32'h02004000, 4'h0, 4'h0, 0, 0, 32'hFFFFFF80, 0, 0);
    add(0, 2'b00, 1, 32'h02004000, 0, 32'h00000080, 0, 1, 1, 1, 2, 32'h02004000, 4'h0, 4'h0, 0, 0, 32'h00000080, 0, 0);
    add(0, 2'b10, 0, 32'h02001000, 0, 32'h12345678, 0, 0, 1, 1, 2, 32'h02001000, 4'h0, 4'h0, 0, 0, 32'h00000000, 1, 0);
    add(0, 2'b11, 0, 32'h00000100, 0, 0, 0, 1, 1, 0, 1, 0, 4'h0, 4'h0, 0, 0, 32'h00000000, 1, 0);
    add(0, 2'b01, 0, 32'h02000002, 0, 32'h80011234, 0, 1, 1, 1, 2, 32'h02000000, 4'h0, 4'h0, 0, 0, 32'hFFFF8001, 0, 0);
    add(1, 2'b01, 0, 32'h02000006, 32'h0000BEEF, 0, 0, 1, 1, 1, 2, 32'h02000004, 4'hC, 4'h0, 32'hBEEF0000, 0, 0, 0, 0);
    add(0, 2'b00, 1, 32'h00000003, 0, 32'hC0112233, 0, 1, 1, 1, 2, 32'h00000000, 4'h0, 4'h0, 0, 0, 32'h000000C0, 0, 0);
    add(0, 2'b01, 1, 32'h02000000, 0, 32'h1234F00D, 0, 1, 1, 1, 2, 32'h02000000, 4'h0, 4'h0, 0, 0, 32'h0000F00D, 0, 0);
    add(1, 2'b00, 0, 32'h02000003, 32'h0000005A, 0, 0, 1, 1, 1, 2, 32'h02000000, 4'h8, 4'h0, 32'h5A000000, 0, 0, 0, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
    add(0, 2'b10, 0, 32'h0200BFFA, 0, 32'h11223344, 32'h55667788, 1, 1, 2, 3, 32'h0200BFF8, 4'h0, 4'h0, 0, 0, 32'h77881122, 0, 0);
    add(1, 2'b01, 0, 32'h02000001, 32'h0000BEEF, 0, 0, 1, 1, 1, 2, 32'h02000000, 4'h6, 4'h0, 32'h00BEEF00, 0, 0, 0, 0);
    add(1, 2'b10, 0, 32'hFFFFFFFE, 32'hAABBCCDD, 0, 0, 1, 1, 2, 3, 32'hFFFFFFFC, 4'hC, 4'h3, 32'hCCDD0000, 32'h0000AABB, 0, 0, 0);
    add(0, 2'b01, 0, 32'h02000003, 0, 32'h11223344, 32'h55667788, 1, 0, 2, 3, 32'h02000000, 4'h0, 4'h0, 0, 0, 32'h00000000, 1, 0);
`else
    add(0, 2'b10, 0, 32'h0200BFFA, 0, 32'h11223344, 32'h55667788, 1, 1, 0, 1, 0, 4'h0, 4'h0, 0, 0, 32'h00000000, 0, 1);
    add(1, 2'b01, 0, 32'h02000001, 32'h0000BEEF, 0, 0, 1, 1, 0, 1, 0, 4'h0, 4'h0, 0, 0, 32'h00000000, 0, 1);
    add(1, 2'b10, 0, 32'hFFFFFFFE, 32'hAABBCCDD, 0, 0, 1, 1, 0, 1, 0, 4'h0, 4'h0, 0, 0, 32'h00000000, 0, 1);
    add(0, 2'b01, 0, 32'h02000003, 0, 32'h11223344, 32'h55667788, 1, 0, 0, 1, 0, 4'h0, 4'h0, 0, 0, 32'h00000000, 0, 1);
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 0, {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_err", 0, {31'd0, rsp_err}, 32'd0);
    chk("reset_rsp_misalign", 0, {31'd0, rsp_misalign}, 32'd0);
    chk("reset_rsp_rdata", 0, rsp_rdata, 32'd0);
    chk("reset_bus_addr", 0, bus_addr, 32'd0);
    chk("reset_bus_wdata", 0, bus_wdata, 32'd0);
    chk("reset_bus_wstrb", 0, {28'd0, bus_wstrb}, 32'd0);
    chk("reset_bus_read_en", 0, {31'd0, bus_read_en}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 0, {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) run_vec(i);

    // Back-to-back: req_valid held high, second accept three cycles after the first
    begin
      logic [3:0] exp_ready;
      logic [3:0] exp_rsp;
      exp_ready = 4'b1001;
      exp_rsp   = 4'b0100;
      bus_addr_valid = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h00000010; req_wdata = 32'h01020304;
      for (int c = 0; c < 4; c++) begin
        chk("b2b_req_ready", 100 + c, {31'd0, req_ready}, {31'd0, exp_ready[c]});
        chk("b2b_rsp_valid", 100 + c, {31'd0, rsp_valid}, {31'd0, exp_rsp[c]});
        if (c == 3) begin
          @(posedge clk);
          #1 req_valid = 1'b0;
          @(negedge clk);
        end else begin
          @(negedge clk);
        end
      end
      chk("b2b_second_beat_wstrb", 104, {28'd0, bus_wstrb}, 32'hF);
      repeat (3) @(negedge clk);
    end

    // Reset during ACC0 aborts with no response and quiet bus
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h02000020; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_beat_wstrb", 200, {28'd0, bus_wstrb}, 32'hF);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", 201, {31'd0, rsp_valid}, 32'd0);
    chk("abort_bus_wstrb", 201, {28'd0, bus_wstrb}, 32'd0);
    chk("abort_bus_addr", 201, bus_addr, 32'd0);
    chk("abort_req_ready", 201, {31'd0, req_ready}, 32'd1);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_rsp", 202 + c, {31'd0, rsp_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
